cache_requester: RTL

- Initiator-side adapter that drives the put/get port of the single-cycle cache model on behalf of a core load/store unit.
- Packs core requests into cache request words and holds at most one load outstanding; stores are fire-and-forget.
- Captures the returned cache row and reports data, MSI state and tag-hit to the core.
- Keeps saturating load/miss statistics.

---
 rtl/cache_requester.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cache_requester.sv
// cache_requester: initiator-side adapter between a core load/store unit and
// the put/get port of the single-cycle cache model. A single pending slot
// packs core requests into cache request words; at most one load is in
// flight, stores are fire-and-forget. Returned rows are reported to the core
// together with a tag-hit flag, and saturating load/miss statistics are kept.
module cache_requester #(
  parameter int STAT_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [31:0]           req_addr,
  input  logic [3:0]            req_byte_en,
  input  logic [31:0]           req_data,
  input  logic                  req_msi_valid,
  input  logic [1:0]            req_msi_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           resp_data,
  output logic [1:0]            resp_msi,
  output logic                  resp_hit,
  output logic                  put_valid,
  input  logic                  put_ready,
  output logic [69:0]           put_request,
  output logic                  get_valid,
  input  logic                  get_ready,
  input  logic [51:0]           get_response,
  output logic [STAT_WIDTH-1:0] stat_loads,
  output logic [STAT_WIDTH-1:0] stat_misses
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_GET = 2'd1,
    RESP     = 2'd2
  } state_t;

  // Saturating increment: holds at all-ones instead of wrapping.
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    end
  endfunction

  // Request word layout: {byte_en, tag, index, data, msi_valid, msi_data, ignore_response}.
  // Only the word address is passed in; byte offset bits are not part of the word.
  function automatic logic [69:0] pack_req(
    input logic [29:0] word_addr,
    input logic [3:0]  byte_en,
    input logic [31:0] data,
    input logic        msi_valid,
    input logic [1:0]  msi_data
  );
    return {byte_en, word_addr[29:12], word_addr[11:0], data, msi_valid, msi_data,
            (byte_en != 4'b0000)};
  endfunction

  state_t                  state_r;
  logic                    pend_valid_r;
  logic [69:0]             pend_req_r;
  logic [17:0]             load_tag_r;
  logic [31:0]             resp_data_r;
  logic [1:0]              resp_msi_r;
  logic                    resp_hit_r;
  logic [STAT_WIDTH-1:0]   stat_loads_r;
  logic [STAT_WIDTH-1:0]   stat_misses_r;

  logic                    pend_is_store_s;
  logic                    put_fire_s;
  logic                    req_ready_s;
  logic                    req_fire_s;
  logic                    row_hit_s;
  logic                    addr_lsb_unused_s;

  assign addr_lsb_unused_s = ^req_addr[1:0];

  // Handshake decode: a new request is taken only in IDLE, into an empty slot or
  // into a slot whose store is leaving this very cycle.
  always_comb begin
    pend_is_store_s = pend_req_r[0];
    put_fire_s      = RST_N && pend_valid_r && put_ready;
    if (RST_N && (state_r == IDLE)) begin
      req_ready_s = !pend_valid_r || (put_fire_s && pend_is_store_s);
    end else begin
      req_ready_s = 1'b0;
    end
    req_fire_s = req_valid && req_ready_s;
    row_hit_s  = (get_response[51:34] == load_tag_r) && (get_response[1:0] != 2'b00);
  end

  assign req_ready   = req_ready_s;
  assign put_valid   = RST_N && pend_valid_r;
  assign put_request = pend_req_r;
  assign get_valid   = RST_N && (state_r == WAIT_GET);
  assign resp_valid  = RST_N && (state_r == RESP);
  assign resp_data   = resp_data_r;
  assign resp_msi    = resp_msi_r;
  assign resp_hit    = resp_hit_r;
  assign stat_loads  = stat_loads_r;
  assign stat_misses = stat_misses_r;

  // Pending slot, load/response FSM and statistics; reset drops everything in flight.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_r       <= IDLE;
      pend_valid_r  <= 1'b0;
      pend_req_r    <= {70{1'b0}};
      load_tag_r    <= 18'h0;
      resp_data_r   <= 32'h0;
      resp_msi_r    <= 2'b00;
      resp_hit_r    <= 1'b0;
      stat_loads_r  <= {STAT_WIDTH{1'b0}};
      stat_misses_r <= {STAT_WIDTH{1'b0}};
    end else begin
      if (req_fire_s) begin
        pend_valid_r <= 1'b1;
        pend_req_r   <= pack_req(req_addr[31:2], req_byte_en, req_data,
                                 req_msi_valid, req_msi_data);
      end else if (put_fire_s) begin
        pend_valid_r <= 1'b0;
      end

      case (state_r)
        IDLE: begin
          if (put_fire_s && !pend_is_store_s) begin
            load_tag_r   <= pend_req_r[65:48];
            stat_loads_r <= sat_inc(stat_loads_r);
            state_r      <= WAIT_GET;
          end
        end
        WAIT_GET: begin
          if (get_ready) begin
            resp_data_r <= get_response[33:2];
            resp_msi_r  <= get_response[1:0];
            resp_hit_r  <= row_hit_s;
            state_r     <= RESP;
          end
        end
        RESP: begin
          if (resp_ready) begin
            if (!resp_hit_r) begin
              stat_misses_r <= sat_inc(stat_misses_r);
            end
            state_r <= IDLE;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule
